// File: rtl/pipeline_sequencer.sv
// Pipeline hazard sequencer: decides per-stage load enables and bubble
// injection for load-use, memory wait, taken branch and HALT drain.
module pipeline_sequencer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  OpcodeID,
   input  logic [3:0]  SrcAID,
   input  logic [3:0]  SrcBID,
   input  logic [3:0]  OpcodeEX,
   input  logic [3:0]  DestEX,
   input  logic [3:0]  OpcodeMEM,
   input  logic        TakenID,
   input  logic        MemReady,
   output logic        PCWrite,
   output logic        IFIDWrite,
   output logic        IDEXWrite,
   output logic        EXMEMWrite,
   output logic        MEMWBWrite,
   output logic        IFIDFlush,
   output logic        IDEXFlush,
   output logic        MEMWBFlush,
   output logic        Halted,
   output logic        MemTimeout,
   output logic [15:0] StallCycles
);

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_JUMP = 4'b0010;
   localparam logic [3:0] OP_HALT = 4'b0011;
   localparam logic [3:0] OP_LBU  = 4'b0100;
   localparam logic [3:0] OP_LW   = 4'b0110;
   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

   state_t      r_state, w_state_next;
   logic [1:0]  r_drain_cnt, w_drain_next;
   logic [7:0]  r_wait_cnt, w_wait_inc;
   logic        r_mem_timeout, r_halted;
   logic [15:0] r_stall_cycles;

   logic w_mem_wait, w_id_uses, w_ex_load, w_load_use, w_wait_active;
   logic w_pc_we, w_ifid_we, w_idex_we, w_exmem_we, w_memwb_we;
   logic w_ifid_fl, w_idex_fl, w_memwb_fl;

   // Memory ops occupy opcodes 01xx
   assign w_mem_wait = (OpcodeMEM[3:2] == 2'b01) && !MemReady;
   assign w_id_uses  = (OpcodeID != OP_NOP) && (OpcodeID != OP_JUMP) && (OpcodeID != OP_HALT);
   assign w_ex_load  = (OpcodeEX == OP_LBU) || (OpcodeEX == OP_LW);
   assign w_load_use = w_ex_load && w_id_uses && (DestEX != 4'd0) &&
                       ((DestEX == SrcAID) || (DestEX == SrcBID));
   assign w_wait_active = w_mem_wait && (r_state != S_HALTED);
   assign w_wait_inc = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;

   always_comb begin
      w_state_next = r_state;
      w_drain_next = r_drain_cnt;
      w_pc_we      = 1'b1;
      w_ifid_we    = 1'b1;
      w_idex_we    = 1'b1;
      w_exmem_we   = 1'b1;
      w_memwb_we   = 1'b1;
      w_ifid_fl    = 1'b0;
      w_idex_fl    = 1'b0;
      w_memwb_fl   = 1'b0;
      case (r_state)
         S_RUN: begin
            if (w_mem_wait) begin
               {w_pc_we, w_ifid_we, w_idex_we, w_exmem_we, w_memwb_we} = 5'b0;
               w_memwb_fl = 1'b1;
            end else if (w_load_use) begin
               w_pc_we   = 1'b0;
               w_ifid_we = 1'b0;
               w_idex_fl = 1'b1;
            end else if (OpcodeID == OP_HALT) begin
               w_pc_we      = 1'b0;
               w_ifid_fl    = 1'b1;
               w_state_next = S_DRAIN;
               w_drain_next = 2'd3;
            end else if (TakenID) begin
               w_ifid_fl = 1'b1;
            end
         end
         S_DRAIN: begin
            w_pc_we   = 1'b0;
            w_ifid_fl = 1'b1;
            if (w_mem_wait) begin
               {w_ifid_we, w_idex_we, w_exmem_we, w_memwb_we} = 4'b0;
               w_memwb_fl = 1'b1;
            end else if (r_drain_cnt == 2'd1) begin
               w_state_next = S_HALTED;
               w_drain_next = 2'd0;
            end else begin
               w_drain_next = r_drain_cnt - 2'd1;
            end
         end
         default: begin
            {w_pc_we, w_ifid_we, w_idex_we, w_exmem_we, w_memwb_we} = 5'b0;
         end
      endcase
      // Reset overrides everything so the pipe is held empty while it is asserted
      if (reset) begin
         w_state_next = S_RUN;
         w_drain_next = 2'd0;
         {w_pc_we, w_ifid_we, w_idex_we, w_exmem_we, w_memwb_we} = 5'b0;
         {w_ifid_fl, w_idex_fl, w_memwb_fl} = 3'b111;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_RUN;
         r_drain_cnt    <= 2'd0;
         r_wait_cnt     <= 8'd0;
         r_mem_timeout  <= 1'b0;
         r_stall_cycles <= 16'd0;
         r_halted       <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_drain_cnt <= w_drain_next;
         r_halted    <= (w_state_next == S_HALTED);
         r_wait_cnt  <= w_wait_active ? w_wait_inc : 8'd0;
         // Compare against the post-increment value so the flag shows right after the N-th wait
         if (w_wait_active && (w_wait_inc == TIMEOUT_CNT))
            r_mem_timeout <= 1'b1;
         if ((r_state != S_HALTED) && !w_pc_we && (r_stall_cycles != 16'hFFFF))
            r_stall_cycles <= r_stall_cycles + 16'd1;
      end
   end

   assign PCWrite     = w_pc_we;
   assign IFIDWrite   = w_ifid_we;
   assign IDEXWrite   = w_idex_we;
   assign EXMEMWrite  = w_exmem_we;
   assign MEMWBWrite  = w_memwb_we;
   assign IFIDFlush   = w_ifid_fl;
   assign IDEXFlush   = w_idex_fl;
   assign MEMWBFlush  = w_memwb_fl;
   assign Halted      = r_halted && !reset;
   assign MemTimeout  = r_mem_timeout && !reset;
   assign StallCycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: default instance plus a MEM_TIMEOUT=3 instance.
module tb_pipeline_sequencer;

   localparam logic [3:0] NOP  = 4'b0000;
   localparam logic [3:0] ADD  = 4'b0001;
   localparam logic [3:0] JUMP = 4'b0010;
   localparam logic [3:0] HALT = 4'b0011;
   localparam logic [3:0] LBU  = 4'b0100;
   localparam logic [3:0] SB   = 4'b0101;
   localparam logic [3:0] LW   = 4'b0110;
   localparam logic [3:0] SW   = 4'b0111;

   logic clk = 1'b0;
   logic reset;
   logic [3:0] OpcodeID, SrcAID, SrcBID, OpcodeEX, DestEX, OpcodeMEM;
   logic TakenID, MemReady;

   logic PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite;
   logic IFIDFlush, IDEXFlush, MEMWBFlush, Halted, MemTimeout;
   logic [15:0] StallCycles;
   logic t_PCWrite, t_IFIDWrite, t_IDEXWrite, t_EXMEMWrite, t_MEMWBWrite;
   logic t_IFIDFlush, t_IDEXFlush, t_MEMWBFlush, t_Halted, t_MemTimeout;
   logic [15:0] t_StallCycles;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipeline_sequencer dut (
      .clk(clk), .reset(reset),
      .OpcodeID(OpcodeID), .SrcAID(SrcAID), .SrcBID(SrcBID),
      .OpcodeEX(OpcodeEX), .DestEX(DestEX), .OpcodeMEM(OpcodeMEM),
      .TakenID(TakenID), .MemReady(MemReady),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
      .EXMEMWrite(EXMEMWrite), .MEMWBWrite(MEMWBWrite),
      .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .MEMWBFlush(MEMWBFlush),
      .Halted(Halted), .MemTimeout(MemTimeout), .StallCycles(StallCycles)
   );

   pipeline_sequencer #(.MEM_TIMEOUT(3)) dut_t (
      .clk(clk), .reset(reset),
      .OpcodeID(OpcodeID), .SrcAID(SrcAID), .SrcBID(SrcBID),
      .OpcodeEX(OpcodeEX), .DestEX(DestEX), .OpcodeMEM(OpcodeMEM),
      .TakenID(TakenID), .MemReady(MemReady),
      .PCWrite(t_PCWrite), .IFIDWrite(t_IFIDWrite), .IDEXWrite(t_IDEXWrite),
      .EXMEMWrite(t_EXMEMWrite), .MEMWBWrite(t_MEMWBWrite),
      .IFIDFlush(t_IFIDFlush), .IDEXFlush(t_IDEXFlush), .MEMWBFlush(t_MEMWBFlush),
      .Halted(t_Halted), .MemTimeout(t_MemTimeout), .StallCycles(t_StallCycles)
   );

   wire [4:0] en = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite};
   wire [2:0] fl = {IFIDFlush, IDEXFlush, MEMWBFlush};

   task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
      $display("check %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   task automatic chk_ctl(input string tag, input logic [4:0] en_exp, input logic [2:0] fl_exp);
      chk({tag, "/en"}, {11'd0, en}, {11'd0, en_exp});
      chk({tag, "/fl"}, {13'd0, fl}, {13'd0, fl_exp});
   endtask

   task automatic drv(input logic [3:0] opid, input logic [3:0] sa, input logic [3:0] sb,
                      input logic [3:0] opex, input logic [3:0] dex, input logic [3:0] opmem,
                      input logic tk, input logic rdy);
      OpcodeID = opid; SrcAID = sa; SrcBID = sb;
      OpcodeEX = opex; DestEX = dex; OpcodeMEM = opmem;
      TakenID = tk; MemReady = rdy;
   endtask

   initial begin
      // Reset forcing, before and after the first edge
      reset = 1'b1;
      drv(NOP, 0, 0, NOP, 0, NOP, 1'b0, 1'b1);
      #1;
      chk_ctl("reset_pre", 5'b00000, 3'b111);
      chk("reset_pre_halted", Halted, 0);
      chk("reset_pre_timeout", MemTimeout, 0);
      @(negedge clk); #1;
      chk_ctl("reset_held", 5'b00000, 3'b111);
      chk("reset_stall", StallCycles, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_ctl("run_idle", 5'b11111, 3'b000);
      chk("run_idle_halted", Halted, 0);

      // Load-use: LW r3 in EX, ADD r3,r5 in ID
      @(negedge clk); drv(ADD, 3, 5, LW, 3, NOP, 1'b0, 1'b1); #1;
      chk_ctl("loaduse", 5'b00111, 3'b010);
      @(negedge clk); drv(ADD, 3, 5, NOP, 0, LW, 1'b0, 1'b1); #1;
      chk_ctl("loaduse_after", 5'b11111, 3'b000);
      chk("loaduse_stall", StallCycles, 1);
      @(negedge clk); drv(ADD, 0, 5, LBU, 0, NOP, 1'b0, 1'b1); #1;
      chk_ctl("loaduse_dest0", 5'b11111, 3'b000);
      @(negedge clk); drv(JUMP, 3, 3, LW, 3, NOP, 1'b0, 1'b1); #1;
      chk_ctl("loaduse_jump_nosrc", 5'b11111, 3'b000);
      @(negedge clk); drv(ADD, 3, 0, SB, 3, NOP, 1'b0, 1'b1); #1;
      chk_ctl("store_in_ex", 5'b11111, 3'b000);
      chk("nostall_count", StallCycles, 1);

      // Four-cycle memory wait on LW in MEM
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk); drv(NOP, 0, 0, NOP, 0, LW, 1'b0, 1'b0); #1;
         chk_ctl($sformatf("memwait%0d", i), 5'b00000, 3'b001);
         chk($sformatf("memwait%0d_to", i), MemTimeout, 0);
         chk($sformatf("memwait%0d_to3", i), t_MemTimeout, (i == 4));
      end
      @(negedge clk); drv(NOP, 0, 0, NOP, 0, LW, 1'b0, 1'b1); #1;
      chk_ctl("memwait_done", 5'b11111, 3'b000);
      chk("memwait_stall", StallCycles, 5);
      chk("memwait_done_to", MemTimeout, 0);
      chk("memwait_done_to3", t_MemTimeout, 1);
      @(negedge clk); drv(ADD, 1, 2, ADD, 1, ADD, 1'b0, 1'b0); #1;
      chk_ctl("nonmem_notready", 5'b11111, 3'b000);

      // Load-use and taken branch together: stall first, then flush
      @(negedge clk); drv(ADD, 2, 7, LW, 7, NOP, 1'b1, 1'b1); #1;
      chk_ctl("lu_taken", 5'b00111, 3'b010);
      @(negedge clk); drv(ADD, 2, 7, NOP, 0, LW, 1'b1, 1'b1); #1;
      chk_ctl("taken_after_lu", 5'b11111, 3'b100);
      chk("taken_stall", StallCycles, 6);

      // HALT with clean memory: Halted at T+4
      @(negedge clk); drv(HALT, 0, 0, NOP, 0, NOP, 1'b0, 1'b1); #1;
      chk_ctl("halt_T", 5'b01111, 3'b100);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk); drv(NOP, 0, 0, (i == 1) ? HALT : NOP, 0, NOP, 1'b0, 1'b1); #1;
         chk_ctl($sformatf("drain%0d", i), 5'b01111, 3'b100);
         chk($sformatf("drain%0d_halted", i), Halted, 0);
      end
      @(negedge clk); drv(NOP, 0, 0, NOP, 0, NOP, 1'b0, 1'b1); #1;
      chk_ctl("halted", 5'b00000, 3'b000);
      chk("halted_flag", Halted, 1);
      chk("halted_stall", StallCycles, 10);
      @(negedge clk); drv(ADD, 1, 1, LW, 1, NOP, 1'b1, 1'b1); #1;
      chk_ctl("halted_ignores", 5'b00000, 3'b000);
      chk("halted_stall_frozen", StallCycles, 10);

      // Reset pulse while halted
      @(negedge clk); reset = 1'b1; drv(NOP, 0, 0, NOP, 0, NOP, 1'b0, 1'b1); #1;
      chk_ctl("reset_in_halt", 5'b00000, 3'b111);
      chk("reset_in_halt_flag", Halted, 0);
      chk("reset_to3_forced", t_MemTimeout, 0);
      @(negedge clk); reset = 1'b0; #1;
      chk_ctl("after_reset", 5'b11111, 3'b000);
      chk("after_reset_halted", Halted, 0);
      chk("after_reset_stall", StallCycles, 0);
      chk("after_reset_to3", t_MemTimeout, 0);

      // HALT with a 2-cycle memory wait in the drain: Halted at T+6
      @(negedge clk); drv(HALT, 0, 0, NOP, 0, NOP, 1'b0, 1'b1); #1;
      chk_ctl("halt2_T", 5'b01111, 3'b100);
      @(negedge clk); drv(NOP, 0, 0, HALT, 0, NOP, 1'b0, 1'b1); #1;
      chk_ctl("halt2_T1", 5'b01111, 3'b100);
      for (int i = 2; i <= 3; i++) begin
         @(negedge clk); drv(NOP, 0, 0, NOP, 0, LW, 1'b0, 1'b0); #1;
         chk($sformatf("halt2_T%0d_en", i), {11'd0, en}, 16'd0);
         chk($sformatf("halt2_T%0d_mwbfl", i), MEMWBFlush, 1);
         chk($sformatf("halt2_T%0d_halted", i), Halted, 0);
      end
      for (int i = 4; i <= 5; i++) begin
         @(negedge clk); drv(NOP, 0, 0, NOP, 0, NOP, 1'b0, 1'b1); #1;
         chk_ctl($sformatf("halt2_T%0d", i), 5'b01111, 3'b100);
         chk($sformatf("halt2_T%0d_halted", i), Halted, 0);
      end
      @(negedge clk); #1;
      chk("halt2_T6_halted", Halted, 1);
      chk_ctl("halt2_T6", 5'b00000, 3'b000);
      chk("halt2_stall", StallCycles, 6);
      chk("halt2_to3", t_MemTimeout, 0);

      // Timeout instance: six wait cycles, sticky until reset
      @(negedge clk); reset = 1'b1; #1;
      @(negedge clk); reset = 1'b0; #1;
      chk_ctl("rerun", 5'b11111, 3'b000);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk); drv(NOP, 0, 0, NOP, 0, SW, 1'b0, 1'b0); #1;
         chk($sformatf("tmo%0d_to3", i), t_MemTimeout, (i >= 4));
         chk($sformatf("tmo%0d_to", i), MemTimeout, 0);
      end
      @(negedge clk); drv(NOP, 0, 0, NOP, 0, SW, 1'b0, 1'b1); #1;
      chk("tmo_ready_to3", t_MemTimeout, 1);
      @(negedge clk); drv(NOP, 0, 0, NOP, 0, NOP, 1'b0, 1'b1); #1;
      chk("tmo_sticky", t_MemTimeout, 1);
      @(negedge clk); reset = 1'b1; #1;
      chk("tmo_reset_forced", t_MemTimeout, 0);
      @(negedge clk); reset = 1'b0; #1;
      chk("tmo_after_reset", t_MemTimeout, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
